// File: rtl/synth_pkg.sv
// synth_pkg: definitions shared by the voice allocator and its LRU tracker.
//   - Register offsets inside a voice's register block (low 6 bits of the
//     synth register number).
//   - AllocState_t: allocator sequencer states.
//   - NoteEvent_t: host event as latched at the handshake. The fields are
//     sized for the widest configuration. Narrower notes are zero-extended.
package synth_pkg;

  localparam logic [5:0] REG_OP1_FREQ = 6'h02;
  localparam logic [5:0] REG_OP2_FREQ = 6'h04;
  localparam logic [5:0] REG_KEYON    = 6'h05;

  localparam int EVT_NOTE_W = 16;
  localparam int EVT_FREQ_W = 24;

  typedef enum logic [2:0] {
    IDLE,
    ALLOC,
    LOOKUP,
    WR_KEYOFF,
    WR_FREQ1,
    WR_FREQ2,
    WR_KEYON
  } AllocState_t;

  typedef struct packed {
    logic                  key_on;
    logic [EVT_NOTE_W-1:0] note;
    logic [EVT_FREQ_W-1:0] freq1;
    logic [EVT_FREQ_W-1:0] freq2;
  } NoteEvent_t;

endpackage

// File: rtl/voice_lru.sv
// voice_lru: per-voice state (active bit, stored note and LRU rank) plus the
// combinational searches the allocator needs.
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   query_note            note searched for among the active voices
//   alloc, alloc_idx      commit an allocation: the voice becomes the newest,
//   alloc_note            and its note is stored
//   set_active/clr_active set or clear the active bit of voice act_idx
//   active                per-voice active bits (index 0 = voice 1)
//   free_hit/free_idx     lowest-numbered inactive voice
//   match_hit/match_idx   active voice holding query_note
//   oldest_idx            voice with rank 0
module voice_lru #(
  parameter int NUM_VOICES = 8,
  parameter int NOTE_WIDTH = 7,
  parameter int IW         = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NOTE_WIDTH-1:0] query_note,
  input  logic                  alloc,
  input  logic [IW-1:0]         alloc_idx,
  input  logic [NOTE_WIDTH-1:0] alloc_note,
  input  logic                  set_active,
  input  logic                  clr_active,
  input  logic [IW-1:0]         act_idx,
  output logic [NUM_VOICES-1:0] active,
  output logic                  free_hit,
  output logic [IW-1:0]         free_idx,
  output logic                  match_hit,
  output logic [IW-1:0]         match_idx,
  output logic [IW-1:0]         oldest_idx
);

  logic [IW-1:0]         rank [NUM_VOICES];
  logic [NOTE_WIDTH-1:0] note [NUM_VOICES];
  logic [IW-1:0]         alloc_rank;

  assign alloc_rank = rank[alloc_idx];

  // Ranks remain a permutation. The allocated voice moves to the top.
  // Every voice above its old slot moves down by one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        rank[v] <= IW'(v);
      end
      active <= '0;
    end else begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        if (alloc) begin
          if (IW'(v) == alloc_idx) begin
            rank[v] <= IW'(NUM_VOICES - 1);
          end else if (rank[v] > alloc_rank) begin
            rank[v] <= rank[v] - 1'b1;
          end
        end
        if (set_active && IW'(v) == act_idx) begin
          active[v] <= 1'b1;
        end else if (clr_active && IW'(v) == act_idx) begin
          active[v] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int v = 0; v < NUM_VOICES; v++) begin
      if (alloc && IW'(v) == alloc_idx) begin
        note[v] <= alloc_note;
      end
    end
  end

  // The scan runs from the top index down, so the last hit is the lowest index.
  always_comb begin
    free_hit   = 1'b0;
    free_idx   = '0;
    match_hit  = 1'b0;
    match_idx  = '0;
    oldest_idx = '0;
    for (int v = NUM_VOICES - 1; v >= 0; v--) begin
      if (!active[v]) begin
        free_hit = 1'b1;
        free_idx = IW'(v);
      end
      if (active[v] && note[v] == query_note) begin
        match_hit = 1'b1;
        match_idx = IW'(v);
      end
      if (rank[v] == '0) begin
        oldest_idx = IW'(v);
      end
    end
  end

endmodule

// File: rtl/voice_allocator.sv
// voice_allocator: polyphonic note scheduler. It accepts note-on and note-off
// events over a valid/ready handshake, picks a voice (1..NUM_VOICES) and emits
// the synth register writes that start or stop that voice.
// Configuration macro: VOICE_STEAL_EN. When it is defined, a note-on that
// finds no free voice steals the least-recently-allocated voice. When it is
// undefined, that note-on is discarded.
// Ports:
//   i_Clock, i_Reset_n          clock, asynchronous active-low reset
//   i_EventValid/o_EventReady   event handshake
//   i_EventKeyOn, i_EventNote   event kind and note
//   i_EventFreq1/2              operator frequencies (note-on only)
//   o_RegisterNumber/Value      {voice[5:0], offset[5:0]} and write data
//   o_RegisterWriteEnable       one-cycle write strobe
//   o_VoiceActive               per-voice key-on state as last written
module voice_allocator
  import synth_pkg::*;
#(
  parameter int NUM_VOICES = 8,
  parameter int NOTE_WIDTH = 7,
  parameter int FREQ_WIDTH = 24
) (
  input  logic                  i_Clock,
  input  logic                  i_Reset_n,
  input  logic                  i_EventValid,
  output logic                  o_EventReady,
  input  logic                  i_EventKeyOn,
  input  logic [NOTE_WIDTH-1:0] i_EventNote,
  input  logic [FREQ_WIDTH-1:0] i_EventFreq1,
  input  logic [FREQ_WIDTH-1:0] i_EventFreq2,
  output logic [11:0]           o_RegisterNumber,
  output logic [23:0]           o_RegisterValue,
  output logic                  o_RegisterWriteEnable,
  output logic [NUM_VOICES:1]   o_VoiceActive
);

  localparam int IW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

  AllocState_t     state, state_next;
  NoteEvent_t      evt;
  logic [IW-1:0]   cur_voice, sel_voice, alloc_choice;
  logic            alloc_ok;
  logic [5:0]      voice_id;
  logic            we_d, set_act, clr_act;
  logic [11:0]     num_d;
  logic [23:0]     val_d;

  logic [NUM_VOICES-1:0] active;
  logic                  free_hit, match_hit;
  logic [IW-1:0]         free_idx, match_idx, oldest_idx;

  voice_lru #(
    .NUM_VOICES (NUM_VOICES),
    .NOTE_WIDTH (NOTE_WIDTH),
    .IW         (IW)
  ) u_lru (
    .clk        (i_Clock),
    .rst_n      (i_Reset_n),
    .query_note (evt.note[NOTE_WIDTH-1:0]),
    .alloc      ((state == ALLOC) && alloc_ok),
    .alloc_idx  (alloc_choice),
    .alloc_note (evt.note[NOTE_WIDTH-1:0]),
    .set_active (set_act),
    .clr_active (clr_act),
    .act_idx    (sel_voice),
    .active     (active),
    .free_hit   (free_hit),
    .free_idx   (free_idx),
    .match_hit  (match_hit),
    .match_idx  (match_idx),
    .oldest_idx (oldest_idx)
  );

  assign o_VoiceActive = active;

  // Voice choice: retrigger match, then a free voice, then the oldest voice.
  always_comb begin
    alloc_choice = oldest_idx;
`ifdef VOICE_STEAL_EN
    alloc_ok     = 1'b1;
`else
    alloc_ok     = 1'b0;
`endif
    if (match_hit) begin
      alloc_choice = match_idx;
      alloc_ok     = 1'b1;
    end else if (free_hit) begin
      alloc_choice = free_idx;
      alloc_ok     = 1'b1;
    end
  end

  // The voice is resolved in ALLOC or LOOKUP and then held for the write sequence.
  always_comb begin
    sel_voice = cur_voice;
    if (state == ALLOC) begin
      sel_voice = alloc_choice;
    end else if (state == LOOKUP) begin
      sel_voice = match_idx;
    end
  end

  assign voice_id = 6'(sel_voice) + 6'd1;

  always_ff @(posedge i_Clock) begin
    cur_voice <= sel_voice;
    if (state == IDLE && i_EventValid) begin
      evt.key_on <= i_EventKeyOn;
      evt.note   <= EVT_NOTE_W'(i_EventNote);
      evt.freq1  <= EVT_FREQ_W'(i_EventFreq1);
      evt.freq2  <= EVT_FREQ_W'(i_EventFreq2);
    end
  end

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:      if (i_EventValid) state_next = i_EventKeyOn ? ALLOC : LOOKUP;
      ALLOC: begin
        if (!alloc_ok)                   state_next = IDLE;
        else if (match_hit || !free_hit) state_next = WR_KEYOFF;
        else                             state_next = WR_FREQ1;
      end
      LOOKUP:    state_next = match_hit ? WR_KEYOFF : IDLE;
      WR_KEYOFF: state_next = evt.key_on ? WR_FREQ1 : IDLE;
      WR_FREQ1:  state_next = WR_FREQ2;
      WR_FREQ2:  state_next = WR_KEYON;
      WR_KEYON:  state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // Write values are decoded from the state being entered, so the registered
  // strobe lines up with the cycle spent in each WR_* state.
  always_comb begin
    we_d    = 1'b0;
    num_d   = o_RegisterNumber;
    val_d   = o_RegisterValue;
    set_act = 1'b0;
    clr_act = 1'b0;
    unique case (state_next)
      WR_KEYOFF: begin
        we_d = 1'b1; num_d = {voice_id, REG_KEYON}; val_d = 24'd0; clr_act = 1'b1;
      end
      WR_FREQ1: begin
        we_d = 1'b1; num_d = {voice_id, REG_OP1_FREQ}; val_d = evt.freq1;
      end
      WR_FREQ2: begin
        we_d = 1'b1; num_d = {voice_id, REG_OP2_FREQ}; val_d = evt.freq2;
      end
      WR_KEYON: begin
        we_d = 1'b1; num_d = {voice_id, REG_KEYON}; val_d = 24'd1; set_act = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      o_EventReady          <= 1'b0;
      o_RegisterWriteEnable <= 1'b0;
      o_RegisterNumber      <= '0;
      o_RegisterValue       <= '0;
    end else begin
      o_EventReady          <= (state_next == IDLE);
      o_RegisterWriteEnable <= we_d;
      o_RegisterNumber      <= num_d;
      o_RegisterValue       <= val_d;
    end
  end

endmodule

// File: tb/tb_voice_allocator.sv
// tb_voice_allocator: directed-vector bench for voice_allocator (8 voices).
// Expected write sequences are tabulated per event as offsets from the
// handshake cycle. Build with or without VOICE_STEAL_EN.
module tb_voice_allocator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ev_valid;
  logic        ev_ready;
  logic        ev_key_on;
  logic [6:0]  ev_note;
  logic [23:0] ev_freq1, ev_freq2;
  logic [11:0] reg_num;
  logic [23:0] reg_val;
  logic        reg_we;
  logic [8:1]  voice_active;

  int checks = 0;
  int errors = 0;

  // expected write table for the event under test
  logic [11:0] e_num [4];
  logic [23:0] e_val [4];
  int          e_n;
  int          e_rdy;

  always #5 clk = ~clk;

  voice_allocator #(
    .NUM_VOICES (8),
    .NOTE_WIDTH (7),
    .FREQ_WIDTH (24)
  ) dut (
    .i_Clock               (clk),
    .i_Reset_n             (rst_n),
    .i_EventValid          (ev_valid),
    .o_EventReady          (ev_ready),
    .i_EventKeyOn          (ev_key_on),
    .i_EventNote           (ev_note),
    .i_EventFreq1          (ev_freq1),
    .i_EventFreq2          (ev_freq2),
    .o_RegisterNumber      (reg_num),
    .o_RegisterValue       (reg_val),
    .o_RegisterWriteEnable (reg_we),
    .o_VoiceActive         (voice_active)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic exp_free(input logic [5:0] v, input logic [23:0] f1, input logic [23:0] f2);
    e_num[0] = {v, 6'h02}; e_val[0] = f1;
    e_num[1] = {v, 6'h04}; e_val[1] = f2;
    e_num[2] = {v, 6'h05}; e_val[2] = 24'd1;
    e_n = 3; e_rdy = 5;
  endtask

  task automatic exp_retrig(input logic [5:0] v, input logic [23:0] f1, input logic [23:0] f2);
    e_num[0] = {v, 6'h05}; e_val[0] = 24'd0;
    e_num[1] = {v, 6'h02}; e_val[1] = f1;
    e_num[2] = {v, 6'h04}; e_val[2] = f2;
    e_num[3] = {v, 6'h05}; e_val[3] = 24'd1;
    e_n = 4; e_rdy = 6;
  endtask

  task automatic wait_ready(input string tag);
    int b;
    b = 0;
    while (ev_ready !== 1'b1 && b < 20) begin
      @(negedge clk);
      b++;
    end
    check({tag, "_ready_timeout"}, 32'(ev_ready), 32'd1);
  endtask

  // Called on a falling edge; the handshake happens at the next rising edge.
  task automatic run_evt(input string tag, input logic kon, input logic [6:0] note,
                         input logic [23:0] f1, input logic [23:0] f2);
    logic exp_we;
    wait_ready(tag);
    ev_valid  = 1'b1;
    ev_key_on = kon;
    ev_note   = note;
    ev_freq1  = f1;
    ev_freq2  = f2;
    for (int off = 1; off <= e_rdy; off++) begin
      @(negedge clk);
      ev_valid = 1'b0;
      check($sformatf("%s_rdy%0d", tag, off), 32'(ev_ready), (off == e_rdy) ? 32'd1 : 32'd0);
      exp_we = (off >= 2) && (off < 2 + e_n);
      check($sformatf("%s_we%0d", tag, off), 32'(reg_we), 32'(exp_we));
      if (exp_we) begin
        check($sformatf("%s_num%0d", tag, off), 32'(reg_num), 32'(e_num[off-2]));
        check($sformatf("%s_val%0d", tag, off), 32'(reg_val), 32'(e_val[off-2]));
      end
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    ev_valid  = 1'b0;
    ev_key_on = 1'b0;
    ev_note   = '0;
    ev_freq1  = '0;
    ev_freq2  = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(ev_ready), 32'd0);
    check("rst_we", 32'(reg_we), 32'd0);
    check("rst_num", 32'(reg_num), 32'd0);
    check("rst_val", 32'(reg_val), 32'd0);
    check("rst_active", 32'(voice_active), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rel_ready", 32'(ev_ready), 32'd1);

    // note-on 60 into voice 1
    e_num[0] = 12'h042; e_val[0] = 24'h001234;
    e_num[1] = 12'h044; e_val[1] = 24'h002468;
    e_num[2] = 12'h045; e_val[2] = 24'h000001;
    e_n = 3; e_rdy = 5;
    run_evt("on60", 1'b1, 7'd60, 24'h001234, 24'h002468);
    check("on60_active", 32'(voice_active), 32'h01);

    // retrigger of note 60 stays on voice 1
    exp_retrig(6'd1, 24'h000AAA, 24'h000BBB);
    run_evt("retrig60", 1'b1, 7'd60, 24'h000AAA, 24'h000BBB);
    check("retrig_active", 32'(voice_active), 32'h01);

    // note-off hit then miss
    e_num[0] = 12'h045; e_val[0] = 24'd0; e_n = 1; e_rdy = 3;
    run_evt("off60", 1'b0, 7'd60, 24'd0, 24'd0);
    check("off60_active", 32'(voice_active), 32'h00);
    e_n = 0; e_rdy = 2;
    run_evt("off61_miss", 1'b0, 7'd61, 24'd0, 24'd0);

    // fill voices 1..8 with notes 61..68
    for (int i = 1; i <= 8; i++) begin
      exp_free(6'(i), 24'h010000 | 24'(60 + i), 24'h020000 | 24'(60 + i));
      run_evt($sformatf("fill%0d", i), 1'b1, 7'(60 + i),
              24'h010000 | 24'(60 + i), 24'h020000 | 24'(60 + i));
    end
    check("full_active", 32'(voice_active), 32'hFF);

    // ninth note: voice 1 is the oldest
`ifdef VOICE_STEAL_EN
    exp_retrig(6'd1, 24'h030046, 24'h040046);
`else
    e_n = 0; e_rdy = 2;
`endif
    run_evt("steal70", 1'b1, 7'd70, 24'h030046, 24'h040046);
    check("steal_active", 32'(voice_active), 32'hFF);

    // reset in the middle of a retrigger of note 65 (voice 5)
    wait_ready("rstmid");
    ev_valid  = 1'b1;
    ev_key_on = 1'b1;
    ev_note   = 7'd65;
    ev_freq1  = 24'hABCDEF;
    ev_freq2  = 24'h123456;
    @(negedge clk);
    ev_valid = 1'b0;
    @(negedge clk);
    check("rstmid_we2", 32'(reg_we), 32'd1);
    check("rstmid_num2", 32'(reg_num), 32'h145);
    check("rstmid_val2", 32'(reg_val), 32'd0);
    @(negedge clk);
    check("rstmid_num3", 32'(reg_num), 32'h142);
    check("rstmid_val3", 32'(reg_val), 32'hABCDEF);
    rst_n = 1'b0;
    #1;
    check("rstmid_we_now", 32'(reg_we), 32'd0);
    check("rstmid_num_now", 32'(reg_num), 32'd0);
    check("rstmid_val_now", 32'(reg_val), 32'd0);
    check("rstmid_active_now", 32'(voice_active), 32'd0);
    check("rstmid_ready_now", 32'(ev_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("rstmid_hold_we%0d", i), 32'(reg_we), 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    check("rstmid_rel_ready", 32'(ev_ready), 32'd1);
    exp_free(6'd1, 24'h000777, 24'h000888);
    run_evt("after_rst", 1'b1, 7'd72, 24'h000777, 24'h000888);
    check("after_rst_active", 32'(voice_active), 32'h01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/voice_allocator.md
# voice_allocator

Polyphonic note scheduler that sits between the host event source and the `synth` register-write port. It accepts note-on and note-off events through a valid/ready handshake and picks a voice (1..NUM_VOICES) for each one, stealing the least-recently-allocated voice when none is free. It then emits the register write sequence (operator frequencies, KeyOn) that starts or stops that voice.

## Interface
- `NUM_VOICES`, default 8: voice count. Voices are numbered 1..NUM_VOICES; the value must be ≤ 63.
- `NOTE_WIDTH`, default 7: note identifier width (MIDI-style).
- `FREQ_WIDTH`, default 24: operator frequency word width. Must equal the synth register value width.
- `i_Clock` in, 1: single clock for all logic.
- `i_Reset_n` in, 1: asynchronous, active-low reset.
- `i_EventValid` in, 1: event present.
- `o_EventReady` out, 1: allocator can accept an event.
- `i_EventKeyOn` in, 1: 1 = note-on, 0 = note-off.
- `i_EventNote` in, NOTE_WIDTH: note identifier.
- `i_EventFreq1` in, FREQ_WIDTH: operator 1 frequency (note-on only).
- `i_EventFreq2` in, FREQ_WIDTH: operator 2 frequency (note-on only).
- `o_RegisterNumber` out, 12: `{voiceID[5:0], offset[5:0]}`.
- `o_RegisterValue` out, 24: write data.
- `o_RegisterWriteEnable` out, 1: one-cycle write strobe.
- `o_VoiceActive` out, NUM_VOICES (indexed NUM_VOICES:1): per-voice key-on state as last written.

## Operation
- Register offsets used:
  - 6'h02: Op1 Frequency.
  - 6'h04: Op2 Frequency.
  - 6'h05: KeyOn, written with value 0 or 1.
- Per-voice state:
  - active bit;
  - stored note;
  - LRU rank 0..NUM_VOICES-1, where 0 = oldest.
- Ranks always form a permutation. Reset gives voice v rank v-1.
- Allocation: the allocated voice gets rank NUM_VOICES-1. Every voice whose rank exceeded the old rank of the allocated voice decrements by 1.
- FSM states: IDLE, ALLOC, LOOKUP, WR_KEYOFF, WR_FREQ1, WR_FREQ2, WR_KEYON.
- IDLE: `o_EventReady`=1. Handshake occurs when valid & ready; event fields are latched. A note-on goes to ALLOC; a note-off goes to LOOKUP.
- ALLOC, voice choice in priority order:
  1. An active voice with a matching note: retrigger.
  2. The lowest-numbered inactive voice.
  3. The rank-0 voice: steal.
- ALLOC next state: retrigger or steal goes to WR_KEYOFF then WR_FREQ1; a free voice goes straight to WR_FREQ1.
- Sequence WR_FREQ1 → WR_FREQ2 → WR_KEYON → IDLE, one write per state.
- The LRU update and the stored note commit in ALLOC.
- LOOKUP: an active voice with a matching note goes to WR_KEYOFF → IDLE. No match goes to IDLE with no write.
- At most one active voice holds a given note; retrigger guarantees this.
- `o_VoiceActive[v]` sets in the WR_KEYON write cycle and clears in the WR_KEYOFF write cycle.
- Outputs are registered. With write enable low, `o_RegisterNumber` and `o_RegisterValue` hold their last values.
- Reset mid-sequence: the sequence is abandoned and no further writes occur. The synth is reset independently.

## Timing
- Reset values:
  - `o_EventReady`=0 during reset, 1 in the first cycle after release.
  - Write enable = 0; register number and value = 0.
  - `o_VoiceActive`=0; all voices inactive.
- Handshake in cycle T. Write strobes by case:
  - Free voice: T+2 (freq1), T+3 (freq2), T+4 (KeyOn=1); ready again at T+5.
  - Retrigger or steal: T+2 (KeyOn=0), T+3, T+4, T+5; ready again at T+6.
  - Note-off hit: T+2 (KeyOn=0); ready at T+3.
  - Note-off miss: no write; ready at T+2.
- `o_EventReady` is low in every non-IDLE state. Events are never buffered. The source must hold valid and data until ready.
- Back-to-back events are accepted on the cycle ready returns high.

## Configuration
- `VOICE_STEAL_EN` defined: steal as described.
- `VOICE_STEAL_EN` undefined, no free voice and no retrigger match:
  - The event is accepted and discarded in ALLOC.
  - No writes and no LRU change.
  - Ready returns at T+2.
- Retrigger behaves the same either way.

## Structure
- Shared package `synth_pkg`:
  - register offset constants `REG_OP1_FREQ`, `REG_OP2_FREQ`, `REG_KEYON`;
  - the state enum `AllocState_t`;
  - the event struct `NoteEvent_t`.
- Sub-module `voice_lru`:
  - holds rank, active and note arrays;
  - combinationally outputs the free-voice, match and oldest-voice indices;
  - takes update strobes from the FSM.

## Test plan
- Reset release: one note-on (note 60, freq1 0x001234, freq2 0x002468) → voice 1 written with regs 0x042=0x001234, 0x044=0x002468, 0x045=1 at T+2..T+4; `o_VoiceActive`=8'h01.
- Eight distinct note-ons followed by a ninth (note 70) → voice 1 (oldest) gets KeyOn=0 at T+2, then frequencies and KeyOn=1; ready at T+6.
- Same ninth-event stimulus with `VOICE_STEAL_EN` undefined → no write strobes; ready at T+2; `o_VoiceActive`=8'hFF unchanged.
- Note-on 60, note-on 60 again → same voice retriggered (0x045=0, freq, freq, 0x045=1); no second voice used.
- Note-off 60 while active → single write 0x045=0 at T+2. Note-off 61 with no matching voice → no write; ready at T+2.
- Assert `i_Reset_n` low at T+3 of a steal sequence → outputs zero immediately, no further strobes; the next note-on after release goes to voice 1.
